// File: rtl/bubble_sort_pkg.sv
// Shared types and the compare-swap decision used by the odd-even transposition sorter.
package bubble_sort_pkg;

    // Elements are widened to this width before comparison, so W must stay below it.
    localparam int CMP_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SORT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    function automatic logic cmp_swap(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             descend,
        input logic             signed_mode
    );
        logic a_gt_b;
        logic b_gt_a;
        a_gt_b = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
        b_gt_a = signed_mode ? ($signed(b) > $signed(a)) : (b > a);
        return descend ? b_gt_a : a_gt_b;
    endfunction

endpackage

// File: rtl/bubble_sort_stream_oe_phase.sv
// One odd-even transposition phase: compare-swaps every pair (j, j+1) whose j parity matches i_odd.
module oe_phase
    import bubble_sort_pkg::*;
#(
    parameter int N       = 8,
    parameter int W       = 8,
    parameter int DESCEND = 0,
    parameter int SIGNED  = 0
) (
    input  logic [N*W-1:0] i_arr,
    input  logic           i_odd,
    output logic [N*W-1:0] o_arr,
    output logic           o_any_swap
);

    logic [N-2:0] w_swap;

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_pair
            localparam logic PAR = 1'(gi % 2);
            logic [W-1:0]     w_lo;
            logic [W-1:0]     w_hi;
            logic [CMP_W-1:0] w_lo_x;
            logic [CMP_W-1:0] w_hi_x;

            assign w_lo = i_arr[gi*W +: W];
            assign w_hi = i_arr[(gi+1)*W +: W];

            if (SIGNED != 0) begin : g_sext
                assign w_lo_x = {{(CMP_W-W){w_lo[W-1]}}, w_lo};
                assign w_hi_x = {{(CMP_W-W){w_hi[W-1]}}, w_hi};
            end else begin : g_zext
                assign w_lo_x = {{(CMP_W-W){1'b0}}, w_lo};
                assign w_hi_x = {{(CMP_W-W){1'b0}}, w_hi};
            end

            assign w_swap[gi] = (i_odd == PAR) &&
                                cmp_swap(w_lo_x, w_hi_x, DESCEND != 0, SIGNED != 0);
        end

        // Pairs of one parity never overlap, so each element sees at most one active swap.
        for (gi = 0; gi < N; gi++) begin : g_elem
            if (gi == 0) begin : g_first
                assign o_arr[0 +: W] = w_swap[0] ? i_arr[W +: W] : i_arr[0 +: W];
            end else if (gi == N - 1) begin : g_last
                assign o_arr[gi*W +: W] = w_swap[gi-1] ? i_arr[(gi-1)*W +: W]
                                                       : i_arr[gi*W +: W];
            end else begin : g_mid
                assign o_arr[gi*W +: W] = w_swap[gi]   ? i_arr[(gi+1)*W +: W] :
                                          w_swap[gi-1] ? i_arr[(gi-1)*W +: W] :
                                                         i_arr[gi*W +: W];
            end
        end
    endgenerate

    assign o_any_swap = |w_swap;

endmodule

// File: rtl/bubble_sort_stream.sv
// Loads a packed vector, sorts it one transposition phase per cycle, then streams it out.
module bubble_sort_stream
    import bubble_sort_pkg::*;
#(
    parameter int N          = 8,
    parameter int W          = 8,
    parameter int DESCEND    = 0,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] data,
    input  logic           en,
    input  logic           out_ready,
    output logic [W-1:0]   data_o,
    output logic [N*W-1:0] data_sort_o,
    output logic           wr_en,
    output logic           last,
    output logic           busy
);

    localparam int PW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);

    state_t         r_state;
    logic [N*W-1:0] r_arr;
    logic [PW-1:0]  r_phase;
    logic [IW-1:0]  r_idx;
    logic           r_prev_noswap;
    logic [W-1:0]   r_data_o;
    logic [N*W-1:0] r_data_sort;
    logic           r_wr_en;
    logic           r_last;
    logic           r_busy;

    logic [N*W-1:0] w_arr_next;
    logic           w_any_swap;
    logic           w_sort_done;
    logic [IW-1:0]  w_idx_next;

    oe_phase #(
        .N       (N),
        .W       (W),
        .DESCEND (DESCEND),
        .SIGNED  (SIGNED)
    ) u_phase (
        .i_arr      (r_arr),
        .i_odd      (r_phase[0]),
        .o_arr      (w_arr_next),
        .o_any_swap (w_any_swap)
    );

    // Two quiet phases in a row cover both parities, so the array is already ordered.
    assign w_sort_done = (r_phase == LAST_PHASE) ||
                         ((EARLY_EXIT != 0) && (r_phase != '0) && r_prev_noswap && !w_any_swap);
    assign w_idx_next  = r_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_arr         <= '0;
            r_phase       <= '0;
            r_idx         <= '0;
            r_prev_noswap <= 1'b0;
            r_data_o      <= '0;
            r_data_sort   <= '0;
            r_wr_en       <= 1'b0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_arr         <= data;
                        r_phase       <= '0;
                        r_prev_noswap <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SORT;
                    end
                end
                SORT: begin
                    r_arr         <= w_arr_next;
                    r_prev_noswap <= !w_any_swap;
                    if (w_sort_done) begin
                        r_data_sort <= w_arr_next;
                        r_data_o    <= w_arr_next[0 +: W];
                        r_idx       <= '0;
                        r_wr_en     <= 1'b1;
                        r_last      <= 1'b0;
                        r_state     <= STREAM;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_wr_en <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx    <= w_idx_next;
                            r_data_o <= r_data_sort[w_idx_next*W +: W];
                            r_last   <= (w_idx_next == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o      = r_data_o;
    assign data_sort_o = r_data_sort;
    assign wr_en       = r_wr_en;
    assign last        = r_last;
    assign busy        = r_busy;

endmodule
